// File: rtl/via_pkg.sv
// Shared constants for the 6522 VIA model: register map, IFR bit positions,
// ACR/PCR field layout and the shift-register / Cx2 mode encodings.
package via_pkg;

  localparam logic [3:0] REG_ORB    = 4'h0;
  localparam logic [3:0] REG_ORA    = 4'h1;
  localparam logic [3:0] REG_DDRB   = 4'h2;
  localparam logic [3:0] REG_DDRA   = 4'h3;
  localparam logic [3:0] REG_T1CL   = 4'h4;
  localparam logic [3:0] REG_T1CH   = 4'h5;
  localparam logic [3:0] REG_T1LL   = 4'h6;
  localparam logic [3:0] REG_T1LH   = 4'h7;
  localparam logic [3:0] REG_T2CL   = 4'h8;
  localparam logic [3:0] REG_T2CH   = 4'h9;
  localparam logic [3:0] REG_SR     = 4'hA;
  localparam logic [3:0] REG_ACR    = 4'hB;
  localparam logic [3:0] REG_PCR    = 4'hC;
  localparam logic [3:0] REG_IFR    = 4'hD;
  localparam logic [3:0] REG_IER    = 4'hE;
  localparam logic [3:0] REG_ORA_NH = 4'hF;

  localparam int IFR_CA2 = 0;
  localparam int IFR_CA1 = 1;
  localparam int IFR_SR  = 2;
  localparam int IFR_CB2 = 3;
  localparam int IFR_CB1 = 4;
  localparam int IFR_T2  = 5;
  localparam int IFR_T1  = 6;

  localparam int ACR_PB7_EN   = 7;
  localparam int ACR_T1_FREE  = 6;
  localparam int ACR_T2_PULSE = 5;
  localparam int ACR_SR_OUT   = 4;

  localparam int PCR_CA1_POS = 0;
  localparam int PCR_CB1_POS = 4;

  typedef enum logic [2:0] {
    SR_OFF, SR_IN_T2, SR_IN_TICK, SR_IN_EXT,
    SR_OUT_FREE, SR_OUT_T2, SR_OUT_TICK, SR_OUT_EXT
  } sr_mode_e;

  typedef enum logic [2:0] {
    C2_IN_NEG, C2_IN_NEG_IND, C2_IN_POS, C2_IN_POS_IND,
    C2_HANDSHAKE, C2_PULSE, C2_LOW, C2_HIGH
  } c2_mode_e;

  function automatic logic edge_hit(input logic pos, input logic now, input logic prev);
    return pos ? (now & ~prev) : (~now & prev);
  endfunction

endpackage

// File: rtl/via_sr.sv
// 6522 shift register with its shift clock sources: T2-rate divider driving
// cb1_out, the slow tick, or rising edges of the external cb1 pin.
module via_sr
  import via_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       slow_clock,
  input  sr_mode_e   mode,
  input  logic       access,
  input  logic       load,
  input  logic [7:0] data_in,
  input  logic       rate_restart,
  input  logic [7:0] rate_latch,
  input  logic       cb1_rise,
  input  logic       cb2_in,
  output logic [7:0] sr,
  output logic       cb1_out,
  output logic       cb2_out,
  output logic       done
);

  logic [7:0] rate_cnt;
  logic [2:0] bit_cnt;
  logic       running;
  logic       cb1_q;
  logic       t2_mode;
  logic       rate_run;
  logic       rate_hit;
  logic       shift_en;

  always_comb begin
    t2_mode  = (mode == SR_IN_T2) || (mode == SR_OUT_T2) || (mode == SR_OUT_FREE);
    rate_run = t2_mode && (running || (mode == SR_OUT_FREE));
    rate_hit = rate_run && slow_clock && (rate_cnt == 8'd0);
    shift_en = 1'b0;
    case (mode)
      SR_IN_T2, SR_OUT_T2, SR_OUT_FREE: shift_en = rate_hit && !cb1_q;
      SR_IN_TICK, SR_OUT_TICK:          shift_en = slow_clock && running;
      SR_IN_EXT, SR_OUT_EXT:            shift_en = cb1_rise && running;
      default:                          shift_en = 1'b0;
    endcase
    done = shift_en && (mode != SR_OUT_FREE) && (bit_cnt == 3'd7);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr       <= 8'h00;
      rate_cnt <= 8'hFF;
      bit_cnt  <= 3'd0;
      running  <= 1'b0;
      cb1_q    <= 1'b1;
    end else begin
      if (rate_restart)
        rate_cnt <= rate_latch;
      else if (rate_run && slow_clock)
        rate_cnt <= (rate_cnt == 8'd0) ? rate_latch : rate_cnt - 8'd1;
      // data moves on the low-to-high transition of the divided clock
      if (rate_hit)
        cb1_q <= ~cb1_q;
      if (access) begin
        if (load)
          sr <= data_in;
        bit_cnt <= 3'd0;
        running <= 1'b1;
      end else if (shift_en) begin
        sr      <= {sr[6:0], mode[2] ? sr[7] : cb2_in};
        bit_cnt <= bit_cnt + 3'd1;
        if (done)
          running <= 1'b0;
      end
    end
  end

  assign cb1_out = t2_mode ? cb1_q : 1'b1;
  assign cb2_out = sr[7];

endmodule

// File: rtl/via_6522.sv
// MOS 6522 VIA: two handshaked 8-bit ports, two 16-bit timers, shift
// register and interrupt logic, all time bases gated by slow_clock.
module via_6522
  import via_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       slow_clock,
  input  logic [3:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       strobe,
  input  logic       we,
  output logic       irq,
  input  logic [7:0] porta_in,
  input  logic [7:0] portb_in,
  output logic [7:0] porta_out,
  output logic [7:0] portb_out,
  input  logic       ca1_in,
  input  logic       ca2_in,
  input  logic       cb1_in,
  input  logic       cb2_in,
  output logic       ca2_out,
  output logic       cb1_out,
  output logic       cb2_out
);

  logic [7:0]  ora, orb, ddra, ddrb, acr, pcr, t2_latch_lo, sr;
  logic [15:0] t1_latch, t1_cnt, t2_cnt;
  logic        t1_armed, t2_armed, pb7;
  logic [6:0]  ifr, ier, ifr_set, ifr_clr;
  logic        ca1_q, ca2_q, cb1_q, cb2_q, pb6_q, ca2_hs, cb2_hs;
  logic        wr, rd, ora_acc, orb_acc, sr_acc, t2l_wr;
  logic        ca1_edge, ca2_edge, cb1_edge, cb2_edge, cb1_rise, pb6_fall;
  logic        t1_flag, t2_dec, t2_flag, sr_done, sr_cb1, sr_cb2;
  c2_mode_e    ca2_mode, cb2_mode;

  always_comb begin
    wr       = strobe && we;
    rd       = strobe && !we;
    ora_acc  = strobe && (addr == REG_ORA);
    orb_acc  = strobe && (addr == REG_ORB);
    sr_acc   = strobe && (addr == REG_SR);
    t2l_wr   = wr && (addr == REG_T2CL);
    ca2_mode = c2_mode_e'(pcr[3:1]);
    cb2_mode = c2_mode_e'(pcr[7:5]);

    ca1_edge = slow_clock && edge_hit(pcr[PCR_CA1_POS], ca1_in, ca1_q);
    cb1_edge = slow_clock && edge_hit(pcr[PCR_CB1_POS], cb1_in, cb1_q);
    ca2_edge = slow_clock && !pcr[3] && edge_hit(pcr[2], ca2_in, ca2_q);
    cb2_edge = slow_clock && !pcr[7] && edge_hit(pcr[6], cb2_in, cb2_q);
    cb1_rise = slow_clock && cb1_in && !cb1_q;
    pb6_fall = slow_clock && pb6_q && !portb_in[6];

    t1_flag  = slow_clock && (t1_cnt == 16'd0) && t1_armed;
    t2_dec   = acr[ACR_T2_PULSE] ? pb6_fall : slow_clock;
    t2_flag  = t2_dec && (t2_cnt == 16'd0) && t2_armed;

    ifr_set          = 7'd0;
    ifr_set[IFR_CA2] = ca2_edge;
    ifr_set[IFR_CA1] = ca1_edge;
    ifr_set[IFR_SR]  = sr_done;
    ifr_set[IFR_CB2] = cb2_edge;
    ifr_set[IFR_CB1] = cb1_edge;
    ifr_set[IFR_T2]  = t2_flag;
    ifr_set[IFR_T1]  = t1_flag;

    // independent Cx2 input modes keep their flag across port accesses
    ifr_clr          = 7'd0;
    ifr_clr[IFR_CA2] = ora_acc && !(ca2_mode inside {C2_IN_NEG_IND, C2_IN_POS_IND});
    ifr_clr[IFR_CA1] = ora_acc;
    ifr_clr[IFR_SR]  = sr_acc;
    ifr_clr[IFR_CB2] = orb_acc && !(cb2_mode inside {C2_IN_NEG_IND, C2_IN_POS_IND});
    ifr_clr[IFR_CB1] = orb_acc;
    ifr_clr[IFR_T2]  = (wr && (addr == REG_T2CH)) || (rd && (addr == REG_T2CL));
    ifr_clr[IFR_T1]  = (wr && ((addr == REG_T1CH) || (addr == REG_T1LH))) ||
                       (rd && (addr == REG_T1CL));
    if (wr && (addr == REG_IFR))
      ifr_clr = ifr_clr | data_in[6:0];

    irq = |(ifr & ier);

    porta_out = ora | ~ddra;
    portb_out = orb | ~ddrb;
    if (acr[ACR_PB7_EN])
      portb_out[7] = pb7;

    ca2_out = 1'b1;
    case (ca2_mode)
      C2_HANDSHAKE, C2_PULSE: ca2_out = ca2_hs;
      C2_LOW:                 ca2_out = 1'b0;
      default:                ca2_out = 1'b1;
    endcase
    cb2_out = 1'b1;
    if (acr[ACR_SR_OUT])
      cb2_out = sr_cb2;
    else begin
      case (cb2_mode)
        C2_HANDSHAKE, C2_PULSE: cb2_out = cb2_hs;
        C2_LOW:                 cb2_out = 1'b0;
        default:                cb2_out = 1'b1;
      endcase
    end
    cb1_out = sr_cb1;
  end

  always_comb begin
    data_out = 8'h00;
    case (addr)
      REG_ORB:             data_out = (orb & ddrb) | (portb_in & ~ddrb);
      REG_ORA, REG_ORA_NH: data_out = porta_in;
      REG_DDRB:            data_out = ddrb;
      REG_DDRA:            data_out = ddra;
      REG_T1CL:            data_out = t1_cnt[7:0];
      REG_T1CH:            data_out = t1_cnt[15:8];
      REG_T1LL:            data_out = t1_latch[7:0];
      REG_T1LH:            data_out = t1_latch[15:8];
      REG_T2CL:            data_out = t2_cnt[7:0];
      REG_T2CH:            data_out = t2_cnt[15:8];
      REG_SR:              data_out = sr;
      REG_ACR:             data_out = acr;
      REG_PCR:             data_out = pcr;
      REG_IFR:             data_out = {irq, ifr};
      REG_IER:             data_out = {1'b1, ier};
      default:             data_out = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ora <= 8'h00;  orb <= 8'h00;  ddra <= 8'h00;  ddrb <= 8'h00;
      acr <= 8'h00;  pcr <= 8'h00;  ifr  <= 7'd0;   ier  <= 7'd0;
      t1_latch <= 16'hFFFF;  t1_cnt <= 16'hFFFF;  t1_armed <= 1'b0;  pb7 <= 1'b1;
      t2_latch_lo <= 8'hFF;  t2_cnt <= 16'hFFFF;  t2_armed <= 1'b0;
      ca1_q <= 1'b0;  ca2_q <= 1'b0;  cb1_q <= 1'b0;  cb2_q <= 1'b0;  pb6_q <= 1'b0;
      ca2_hs <= 1'b1;  cb2_hs <= 1'b1;
    end else begin
      if (wr) begin
        case (addr)
          REG_ORB:             orb  <= data_in;
          REG_ORA, REG_ORA_NH: ora  <= data_in;
          REG_DDRB:            ddrb <= data_in;
          REG_DDRA:            ddra <= data_in;
          REG_ACR:             acr  <= data_in;
          REG_PCR:             pcr  <= data_in;
          REG_IER:             ier  <= data_in[7] ? (ier | data_in[6:0]) : (ier & ~data_in[6:0]);
          default: ;
        endcase
      end
      ifr <= (ifr | ifr_set) & ~ifr_clr;

      if (wr && ((addr == REG_T1CL) || (addr == REG_T1LL)))
        t1_latch[7:0] <= data_in;
      if (wr && ((addr == REG_T1CH) || (addr == REG_T1LH)))
        t1_latch[15:8] <= data_in;
      if (wr && (addr == REG_T1CH)) begin
        t1_cnt   <= {data_in, t1_latch[7:0]};
        t1_armed <= 1'b1;
        pb7      <= 1'b0;
      end else if (slow_clock) begin
        if (t1_cnt == 16'd0) begin
          t1_cnt <= t1_latch;
          if (t1_armed) begin
            pb7 <= ~pb7;
            if (!acr[ACR_T1_FREE])
              t1_armed <= 1'b0;
          end
        end else
          t1_cnt <= t1_cnt - 16'd1;
      end

      if (t2l_wr)
        t2_latch_lo <= data_in;
      if (wr && (addr == REG_T2CH)) begin
        t2_cnt   <= {data_in, t2_latch_lo};
        t2_armed <= 1'b1;
      end else if (t2_dec) begin
        t2_cnt <= t2_cnt - 16'd1;
        if (t2_flag)
          t2_armed <= 1'b0;
      end

      if (slow_clock) begin
        ca1_q <= ca1_in;  ca2_q <= ca2_in;  cb1_q <= cb1_in;
        cb2_q <= cb2_in;  pb6_q <= portb_in[6];
      end

      if (ora_acc && (ca2_mode inside {C2_HANDSHAKE, C2_PULSE}))
        ca2_hs <= 1'b0;
      else if (!(ca2_mode inside {C2_HANDSHAKE, C2_PULSE}) ||
               ((ca2_mode == C2_HANDSHAKE) && ca1_edge) ||
               ((ca2_mode == C2_PULSE) && slow_clock))
        ca2_hs <= 1'b1;
      if (orb_acc && (cb2_mode inside {C2_HANDSHAKE, C2_PULSE}))
        cb2_hs <= 1'b0;
      else if (!(cb2_mode inside {C2_HANDSHAKE, C2_PULSE}) ||
               ((cb2_mode == C2_HANDSHAKE) && cb1_edge) ||
               ((cb2_mode == C2_PULSE) && slow_clock))
        cb2_hs <= 1'b1;
    end
  end

  via_sr u_sr (
    .clk          (clk),
    .reset        (reset),
    .slow_clock   (slow_clock),
    .mode         (sr_mode_e'(acr[4:2])),
    .access       (sr_acc),
    .load         (we),
    .data_in      (data_in),
    .rate_restart (sr_acc || t2l_wr),
    .rate_latch   (t2l_wr ? data_in : t2_latch_lo),
    .cb1_rise     (cb1_rise),
    .cb2_in       (cb2_in),
    .sr           (sr),
    .cb1_out      (sr_cb1),
    .cb2_out      (sr_cb2),
    .done         (sr_done)
  );

endmodule

// File: tb/tb_via_6522.sv
// Directed self-checking bench for via_6522: register map, ports, timers,
// shift register, CA1/CA2 handshake and mid-operation reset.
module tb_via_6522;

  logic       clk = 1'b0;
  logic       reset, slow_clock, strobe, we;
  logic [3:0] addr;
  logic [7:0] data_in, data_out, porta_in, portb_in, porta_out, portb_out;
  logic       irq, ca1_in, ca2_in, cb1_in, cb2_in, ca2_out, cb1_out, cb2_out;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  via_6522 dut (
    .clk(clk), .reset(reset), .slow_clock(slow_clock), .addr(addr),
    .data_in(data_in), .data_out(data_out), .strobe(strobe), .we(we), .irq(irq),
    .porta_in(porta_in), .portb_in(portb_in), .porta_out(porta_out), .portb_out(portb_out),
    .ca1_in(ca1_in), .ca2_in(ca2_in), .cb1_in(cb1_in), .cb2_in(cb2_in),
    .ca2_out(ca2_out), .cb1_out(cb1_out), .cb2_out(cb2_out)
  );

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    addr = a; data_in = d; we = 1'b1; strobe = 1'b1;
    @(posedge clk); #1;
    strobe = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    addr = a; we = 1'b0; strobe = 1'b1;
    #1 d = data_out;
    @(posedge clk); #1;
    strobe = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      slow_clock = 1'b1;
      @(posedge clk); #1;
      slow_clock = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [3:0] ra [5] = '{4'h2, 4'h3, 4'hB, 4'hC, 4'hE};
    logic [7:0] ex [5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
    logic [7:0] v;
    for (int i = 0; i < 5; i++) begin
      rd(ra[i], v);
      checks++;
      if (v !== ex[i]) begin errors++; $display("FAIL reset_reg%0h got %h want %h", ra[i], v, ex[i]); end
    end
    checks++;
    if ({irq, porta_out, portb_out, ca2_out, cb1_out, cb2_out} !== {1'b0, 8'hFF, 8'hFF, 3'b111}) begin
      errors++;
      $display("FAIL reset_pins got irq=%b pa=%h pb=%h c=%b%b%b want 0 ff ff 111",
               irq, porta_out, portb_out, ca2_out, cb1_out, cb2_out);
    end
    rd(4'h5, v);
    checks++; if (v !== 8'hFF) begin errors++; $display("FAIL reset_t1ch got %h want ff", v); end
    rd(4'h9, v);
    checks++; if (v !== 8'hFF) begin errors++; $display("FAIL reset_t2ch got %h want ff", v); end
  endtask

  task automatic test_ports();
    logic [7:0] v;
    wr(4'h3, 8'hFF); wr(4'h1, 8'h5A);
    checks++; if (porta_out !== 8'h5A) begin errors++; $display("FAIL porta_out got %h want 5a", porta_out); end
    porta_in = 8'h3C;
    rd(4'h1, v);
    checks++; if (v !== 8'h3C) begin errors++; $display("FAIL ira_read got %h want 3c", v); end
    wr(4'h2, 8'h0F); portb_in = 8'hA0; wr(4'h0, 8'h03);
    rd(4'h0, v);
    checks++; if (v !== 8'hA3) begin errors++; $display("FAIL irb_read got %h want a3", v); end
    checks++; if (portb_out !== 8'hF3) begin errors++; $display("FAIL portb_out got %h want f3", portb_out); end
  endtask

  task automatic test_sr_rate();
    logic [7:0] v;
    wr(4'hB, 8'h10); wr(4'hA, 8'h0F); wr(4'h8, 8'd238);
    cyc(10);
    rd(4'hA, v);
    checks++; if (v !== 8'h0F) begin errors++; $display("FAIL sr_readback got %h want 0f", v); end
    tick(238);
    checks++; if (cb1_out !== 1'b1) begin errors++; $display("FAIL sr_cb1_early got %b want 1", cb1_out); end
    tick(1);
    checks++; if (cb1_out !== 1'b0) begin errors++; $display("FAIL sr_cb1_toggle got %b want 0", cb1_out); end
    tick(238);
    checks++; if (cb1_out !== 1'b0) begin errors++; $display("FAIL sr_cb1_hold got %b want 0", cb1_out); end
    tick(1);
    checks++; if ({cb1_out, cb2_out} !== 2'b10) begin errors++; $display("FAIL sr_cb_pins got %b%b want 10", cb1_out, cb2_out); end
    rd(4'hA, v);
    checks++; if (v !== 8'h1E) begin errors++; $display("FAIL sr_shifted got %h want 1e", v); end
    wr(4'hB, 8'h00);
    checks++; if ({cb1_out, cb2_out} !== 2'b11) begin errors++; $display("FAIL sr_off_pins got %b%b want 11", cb1_out, cb2_out); end
  endtask

  task automatic test_sr_done();
    logic [7:0] v;
    wr(4'hE, 8'h84); wr(4'hB, 8'h18); wr(4'hA, 8'h81);
    checks++; if (cb2_out !== 1'b1) begin errors++; $display("FAIL srd_cb2_start got %b want 1", cb2_out); end
    tick(1);
    checks++; if (cb2_out !== 1'b0) begin errors++; $display("FAIL srd_cb2_shift got %b want 0", cb2_out); end
    tick(6);
    rd(4'hD, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL srd_ifr_7 got %h want 00", v); end
    tick(1);
    rd(4'hD, v);
    checks++; if (v !== 8'h84) begin errors++; $display("FAIL srd_ifr_8 got %h want 84", v); end
    rd(4'hA, v);
    checks++; if (v !== 8'h81) begin errors++; $display("FAIL srd_value got %h want 81", v); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL srd_irq_clear got %b want 0", irq); end
    tick(1);
    checks++; if (cb2_out !== 1'b0) begin errors++; $display("FAIL srd_restart got %b want 0", cb2_out); end
    wr(4'hB, 8'h00); wr(4'hE, 8'h04);
  endtask

  task automatic test_t1();
    logic [7:0] v;
    wr(4'hE, 8'hC0); wr(4'h6, 8'h05); wr(4'h7, 8'h00); wr(4'h5, 8'h00);
    tick(5);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL t1_early got %b want 0", irq); end
    tick(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL t1_fire got %b want 1", irq); end
    rd(4'hD, v);
    checks++; if (v !== 8'hC0) begin errors++; $display("FAIL t1_ifr got %h want c0", v); end
    rd(4'h4, v);
    checks++; if ({v, irq} !== {8'h05, 1'b0}) begin errors++; $display("FAIL t1_clear got %h/%b want 05/0", v, irq); end
    wr(4'hB, 8'h40); wr(4'h5, 8'h00);
    tick(6);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL t1_free1 got %b want 1", irq); end
    rd(4'h4, v);
    tick(5);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL t1_free_gap got %b want 0", irq); end
    tick(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL t1_free2 got %b want 1", irq); end
    rd(4'h4, v);
    wr(4'hB, 8'hC0); wr(4'h5, 8'h00);
    checks++; if (portb_out !== 8'h73) begin errors++; $display("FAIL t1_pb7_arm got %h want 73", portb_out); end
    tick(6);
    checks++; if (portb_out !== 8'hF3) begin errors++; $display("FAIL t1_pb7_toggle got %h want f3", portb_out); end
    wr(4'hB, 8'h00); wr(4'hE, 8'h40); wr(4'hD, 8'h7F);
  endtask

  task automatic test_t2();
    logic [7:0] v;
    wr(4'hE, 8'hA0); wr(4'h8, 8'h03); wr(4'h9, 8'h00);
    tick(3);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL t2_early got %b want 0", irq); end
    tick(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL t2_fire got %b want 1", irq); end
    rd(4'h9, v);
    checks++; if (v !== 8'hFF) begin errors++; $display("FAIL t2_wrap got %h want ff", v); end
    rd(4'h8, v);
    checks++; if ({v, irq} !== {8'hFF, 1'b0}) begin errors++; $display("FAIL t2_clear got %h/%b want ff/0", v, irq); end
    wr(4'hB, 8'h20); wr(4'h9, 8'h00);
    tick(3);
    portb_in = 8'hE0; tick(1);
    portb_in = 8'hA0; tick(1);
    rd(4'h8, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL t2_pulse got %h want 02", v); end
    wr(4'hB, 8'h00); wr(4'hE, 8'h20);
  endtask

  task automatic test_ca1();
    logic [7:0] v;
    wr(4'hD, 8'h7F); wr(4'hC, 8'h01); wr(4'hE, 8'h82);
    ca1_in = 1'b1; cyc(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ca1_no_tick got %b want 0", irq); end
    tick(1);
    rd(4'hD, v);
    checks++; if (v !== 8'h82) begin errors++; $display("FAIL ca1_ifr got %h want 82", v); end
    rd(4'h1, v);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ca1_clear got %b want 0", irq); end
    ca1_in = 1'b0; tick(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ca1_wrong_edge got %b want 0", irq); end
    wr(4'hE, 8'h02);
  endtask

  task automatic test_ca2();
    logic [7:0] v;
    wr(4'hC, 8'h0C);
    checks++; if (ca2_out !== 1'b0) begin errors++; $display("FAIL ca2_manual_low got %b want 0", ca2_out); end
    wr(4'hC, 8'h0E);
    checks++; if (ca2_out !== 1'b1) begin errors++; $display("FAIL ca2_manual_high got %b want 1", ca2_out); end
    wr(4'hC, 8'h08); rd(4'h1, v);
    checks++; if (ca2_out !== 1'b0) begin errors++; $display("FAIL ca2_hs_low got %b want 0", ca2_out); end
    ca1_in = 1'b1; tick(1);
    checks++; if (ca2_out !== 1'b0) begin errors++; $display("FAIL ca2_hs_hold got %b want 0", ca2_out); end
    ca1_in = 1'b0; tick(1);
    checks++; if (ca2_out !== 1'b1) begin errors++; $display("FAIL ca2_hs_release got %b want 1", ca2_out); end
    wr(4'hC, 8'h0A); rd(4'h1, v);
    checks++; if (ca2_out !== 1'b0) begin errors++; $display("FAIL ca2_pulse_low got %b want 0", ca2_out); end
    tick(1);
    checks++; if (ca2_out !== 1'b1) begin errors++; $display("FAIL ca2_pulse_end got %b want 1", ca2_out); end
    wr(4'hC, 8'hC0);
    checks++; if (cb2_out !== 1'b0) begin errors++; $display("FAIL cb2_manual_low got %b want 0", cb2_out); end
    wr(4'hC, 8'h00);
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    wr(4'hE, 8'hA0); wr(4'h8, 8'h02); wr(4'h9, 8'h00);
    tick(1);
    reset = 1'b1; cyc(1); reset = 1'b0;
    checks++; if ({irq, cb2_out} !== 2'b01) begin errors++; $display("FAIL mid_reset_pins got %b%b want 01", irq, cb2_out); end
    rd(4'hE, v);
    checks++; if (v !== 8'h80) begin errors++; $display("FAIL mid_reset_ier got %h want 80", v); end
    tick(3);
    rd(4'h8, v);
    checks++; if ({v, irq} !== {8'hFC, 1'b0}) begin errors++; $display("FAIL mid_reset_t2 got %h/%b want fc/0", v, irq); end
  endtask

  initial begin
    reset = 1'b1; slow_clock = 1'b0; strobe = 1'b0; we = 1'b0;
    addr = 4'h0; data_in = 8'h00; porta_in = 8'h00; portb_in = 8'h00;
    ca1_in = 1'b0; ca2_in = 1'b0; cb1_in = 1'b0; cb2_in = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    test_reset();
    test_ports();
    test_sr_rate();
    test_sr_done();
    test_t1();
    test_t2();
    test_ca1();
    test_ca2();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
